// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray-code helpers for the async FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;

  // Helpers work on a wide container; callers zero-extend narrower pointers,
  // which leaves the low bits of either conversion unaffected.
  localparam int GRAY_W = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
    logic [GRAY_W-1:0] bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for multi-bit Gray-coded buses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/write_ctrl.sv
// ============================================================================
// Module      : write_ctrl
// Description : Write-side controller of the dual-clock FIFO: SRAM write port,
//               Gray write pointer export, full/almost-full/free/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_ctrl #(
  parameter int ADDR_W       = fifo_pkg::ADDR_W,
  parameter int AFULL_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr_gray_async,
  input  logic              ovf_clr,
  output logic              wr_mem_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   gray_wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   free_cnt,
  output logic              overflow
);

  import fifo_pkg::GRAY_W;
  import fifo_pkg::bin2gray;
  import fifo_pkg::gray2bin;

  localparam int                 c_PTR_W = ADDR_W + 1;
  localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(1 << ADDR_W);
  localparam logic [c_PTR_W-1:0] c_AFULL = c_PTR_W'(AFULL_THRESH);

  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_gray_wptr;
  logic               r_overflow;

  logic [c_PTR_W-1:0] w_rptr_sync;
  logic [c_PTR_W-1:0] w_rptr_bin;
  logic [c_PTR_W-1:0] w_wptr_next;
  logic [c_PTR_W-1:0] w_gray_next;
  logic [c_PTR_W-1:0] w_used;
  logic               w_full;
  logic               w_accept;

  sync_2ff #(
    .WIDTH (c_PTR_W)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (w_rptr_sync)
  );

  assign w_rptr_bin = c_PTR_W'(gray2bin(GRAY_W'(w_rptr_sync)));

  // Occupancy uses the extra pointer bit so that full and empty differ.
  assign w_used   = r_wptr - w_rptr_bin;
  assign w_full   = (w_used == c_DEPTH);
  assign w_accept = wr & ~w_full;

  assign w_wptr_next = r_wptr + c_PTR_W'(w_accept);
  assign w_gray_next = c_PTR_W'(bin2gray(GRAY_W'(w_wptr_next)));

  // Binary and Gray pointers share one edge so the exported Gray value
  // only ever moves by a single bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_gray_wptr <= '0;
    end else begin
      r_wptr      <= w_wptr_next;
      r_gray_wptr <= w_gray_next;
    end
  end

  // Setting takes priority so a clear cannot hide a concurrent overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr && w_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign wr_mem_en   = w_accept;
  assign waddr       = r_wptr[ADDR_W-1:0];
  assign wptr        = r_wptr;
  assign gray_wptr   = r_gray_wptr;
  assign full        = w_full;
  assign almost_full = (w_used >= c_AFULL);
  assign free_cnt    = c_DEPTH - w_used;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_write_ctrl.sv
// ============================================================================
// Module      : tb_write_ctrl
// Description : Directed self-checking bench for write_ctrl (ADDR_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_ctrl;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [3:0] rptr_gray_async;
  logic       ovf_clr;
  logic       wr_mem_en;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic [3:0] gray_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] free_cnt;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  write_ctrl #(
    .ADDR_W       (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr),
    .rptr_gray_async (rptr_gray_async),
    .ovf_clr         (ovf_clr),
    .wr_mem_en       (wr_mem_en),
    .waddr           (waddr),
    .wptr            (wptr),
    .gray_wptr       (gray_wptr),
    .full            (full),
    .almost_full     (almost_full),
    .free_cnt        (free_cnt),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, "_wptr"}, 32'(wptr), 32'd0);
    check({tag, "_gray"}, 32'(gray_wptr), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_free"}, 32'(free_cnt), 32'd8);
    check({tag, "_afull"}, 32'(almost_full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_wptr;
    logic [3:0] prev_gray;

    rst = 1'b1;
    wr = 1'b0;
    ovf_clr = 1'b0;
    rptr_gray_async = 4'd0;
    repeat (3) tick();
    check_idle_reset("rst");
    check("rst_wen", 32'(wr_mem_en), 32'd0);
    rst = 1'b0;
    tick();
    check_idle_reset("idle");

    // Fill the FIFO with the read pointer parked at zero.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      #1;
      check("fill_wen", 32'(wr_mem_en), 32'd1);
      check("fill_waddr", 32'(waddr), 32'(i));
      tick();
      check("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
    end
    wr = 1'b0;
    #1;
    check("full_wptr", 32'(wptr), 32'h8);
    check("full_gray", 32'(gray_wptr), 32'hC);
    check("full_full", 32'(full), 32'd1);
    check("full_free", 32'(free_cnt), 32'd0);

    // Overflow set, set-wins-over-clear, then clear.
    wr = 1'b1;
    #1;
    check("ovf_wen", 32'(wr_mem_en), 32'd0);
    tick();
    check("ovf_wptr", 32'(wptr), 32'h8);
    check("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    check("ovf_setwins", 32'(overflow), 32'd1);
    wr = 1'b0;
    tick();
    check("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;

    // Read pointer advance takes two edges to reach full/free_cnt.
    rptr_gray_async = 4'b0001;
    tick();
    check("rd1_full", 32'(full), 32'd1);
    check("rd1_free", 32'(free_cnt), 32'd0);
    tick();
    check("rd2_full", 32'(full), 32'd0);
    check("rd2_free", 32'(free_cnt), 32'd1);
    wr = 1'b1;
    #1;
    check("rd2_wen", 32'(wr_mem_en), 32'd1);
    check("rd2_waddr", 32'(waddr), 32'd0);
    tick();
    wr = 1'b0;
    check("rd2_wptr", 32'(wptr), 32'h9);
    check("rd2_refull", 32'(full), 32'd1);

    // Wrap: read pointer trails the write pointer by two entries.
    exp_wptr = 4'h9;
    rptr_gray_async = g4(exp_wptr - 4'd2);
    repeat (2) tick();
    check("wrap_pre_free", 32'(free_cnt), 32'd6);
    for (int i = 0; i < 16; i++) begin
      prev_gray = gray_wptr;
      wr = 1'b1;
      tick();
      wr = 1'b0;
      exp_wptr = exp_wptr + 4'd1;
      check("wrap_wptr", 32'(wptr), 32'(exp_wptr));
      check("wrap_gray", 32'(gray_wptr), 32'(g4(exp_wptr)));
      check("wrap_1bit", 32'($countones(gray_wptr ^ prev_gray)), 32'd1);
      check("wrap_nofull", 32'(full), 32'd0);
      rptr_gray_async = g4(exp_wptr - 4'd2);
      repeat (2) tick();
      check("wrap_free", 32'(free_cnt), 32'd6);
    end

    // Asynchronous reset in the middle of a burst.
    rst = 1'b1;
    rptr_gray_async = 4'd0;
    tick();
    rst = 1'b0;
    tick();
    wr = 1'b1;
    repeat (5) tick();
    check("burst_wptr", 32'(wptr), 32'h5);
    #2;
    rst = 1'b1;
    wr = 1'b0;
    #1;
    check_idle_reset("arst");
    check("arst_wen", 32'(wr_mem_en), 32'd0);
    #1;
    rst = 1'b0;
    wr = 1'b1;
    #1;
    check("post_wen", 32'(wr_mem_en), 32'd1);
    check("post_waddr", 32'(waddr), 32'd0);
    tick();
    wr = 1'b0;
    check("post_wptr", 32'(wptr), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
